alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter in front of a single compare-and-add/subtract ALU.
// Up to NREQ requesters each present an operand pair (A, B). One requester is
// granted at a time. Its operands are latched, and one cycle later the result
// is registered:
//   RES_DATA = A + B  when A > B (unsigned)
//   RES_DATA = A - B  otherwise
// Arithmetic wraps modulo 2^WIDTH. The result is held until the consumer
// accepts it. While the result is being accepted, the next request can be
// granted in the same cycle, which gives one result every two cycles.
//
// Ports
//   CLK        in   1            clock, all state updates on the rising edge
//   RST_N      in   1            asynchronous active-low reset
//   REQ_VALID  in   NREQ         per-requester request
//   REQ_A      in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   REQ_B      in   NREQ*WIDTH   operand B, same packing as REQ_A
//   REQ_READY  out  NREQ         one-hot grant, combinational, grant cycle only
//   RES_VALID  out  1            result available (FSM is in DONE)
//   RES_READY  in   1            consumer accepts the result
//   RES_DATA   out  WIDTH        result value
//   RES_ID     out  log2(NREQ)   requester that owns RES_DATA
//   DONE_CNT   out  16           number of results handed off (wrapping)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NREQ-1:0]           REQ_VALID,
    input  logic [NREQ*WIDTH-1:0]     REQ_A,
    input  logic [NREQ*WIDTH-1:0]     REQ_B,
    output logic [NREQ-1:0]           REQ_READY,
    output logic                      RES_VALID,
    input  logic                      RES_READY,
    output logic [WIDTH-1:0]          RES_DATA,
    output logic [$clog2(NREQ)-1:0]   RES_ID,
    output logic [15:0]               DONE_CNT
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     gid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_data_q;
    logic [IDW-1:0]     res_id_q;
    logic               res_valid_q;
    logic [15:0]        done_cnt_q;

    // Per-requester operand slices
    logic [WIDTH-1:0]   a_slot [NREQ];
    logic [WIDTH-1:0]   b_slot [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign a_slot[gi] = REQ_A[gi*WIDTH +: WIDTH];
            assign b_slot[gi] = REQ_B[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: start at ptr_q and walk upward. Because NREQ is a
    // power of two, the index wraps modulo NREQ through plain truncation.
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] cand;
            cand = ptr_q + IDW'(k);
            if (!grant_found && REQ_VALID[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant can be issued only when the ALU is free. That is the case in
    // IDLE, or in DONE during the cycle where the held result is accepted.
    logic grant_window;
    logic do_grant;

    assign grant_window = (state_q == S_IDLE) ||
                          ((state_q == S_DONE) && RES_READY);
    assign do_grant     = grant_window && grant_found;

    // REQ_READY is gated with RST_N so it reads all-zero during reset even
    // when requests are pending. In reset the state is IDLE, which would
    // otherwise open the grant window.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign REQ_READY[gi] = RST_N && do_grant && (grant_idx == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            // Operand capture is shared by the IDLE and DONE grant paths.
            if (do_grant) begin
                a_q   <= a_slot[grant_idx];
                b_q   <= b_slot[grant_idx];
                gid_q <= grant_idx;
                ptr_q <= grant_idx + IDW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (do_grant) begin
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (a_q > b_q) begin
                        res_data_q <= a_q + b_q;
                    end else begin
                        res_data_q <= a_q - b_q;
                    end
                    res_id_q    <= gid_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end

                S_DONE: begin
                    // Result and ID are held until the consumer accepts.
                    if (RES_READY) begin
                        done_cnt_q  <= done_cnt_q + 16'd1;
                        res_valid_q <= 1'b0;
                        state_q     <= do_grant ? S_EXEC : S_IDLE;
                    end
                end

                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_ID    = res_id_q;
    assign DONE_CNT  = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter with NREQ=4 and WIDTH=8. The expected
// values are computed by hand from the compare-and-add/subtract rule.
// Inputs change on the falling edge. Registered outputs are sampled 1 ns after
// the rising edge. The combinational grant is sampled 1 ns after its inputs
// settle.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic [15:0] done_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    alu_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ_VALID (req_valid),
        .REQ_A     (req_a),
        .REQ_B     (req_b),
        .REQ_READY (req_ready),
        .RES_VALID (res_valid),
        .RES_READY (res_ready),
        .RES_DATA  (res_data),
        .RES_ID    (res_id),
        .DONE_CNT  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs one request on an otherwise idle block with RES_READY held high.
    task automatic run_single(input int idx, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_d);
        @(negedge clk);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_valid = 4'(1 << idx);
        res_ready = 1'b1;
        #1 chk("grant", 32'(req_ready), 32'(1 << idx));
        @(posedge clk);
        #1 chk("exec_ready_low", 32'(req_ready), 0);
        chk("exec_no_valid", 32'(res_valid), 0);
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1 chk("done_valid", 32'(res_valid), 1);
        chk("done_data", 32'(res_data), 32'(exp_d));
        chk("done_id", 32'(res_id), 32'(idx));
        @(posedge clk);
        exp_cnt++;
        #1 chk("handoff_valid", 32'(res_valid), 0);
        chk("handoff_cnt", 32'(done_cnt), 32'(exp_cnt));
        $display("op id=%0d a=%0d b=%0d res=%0d cnt=%0d", idx, a, b, exp_d, done_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_cnt", 32'(done_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requests: add, subtract with wrap, equal operands, add with wrap
        run_single(0, 8'd20, 8'd5, 8'd25);
        run_single(1, 8'd3, 8'd7, 8'd252);
        run_single(2, 8'd9, 8'd9, 8'd0);
        run_single(3, 8'd200, 8'd100, 8'd44);

        // Round-robin with all four requests held; the pointer is back at 0
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i + 10);
            req_b[i*8 +: 8] = 8'd1;
        end
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1 chk("rr_first_grant", 32'(req_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(posedge clk);
            #1 chk("rr_valid", 32'(res_valid), 1);
            chk("rr_id", 32'(res_id), 32'(k % 4));
            chk("rr_data", 32'(res_data), 32'((k % 4) + 11));
            chk("rr_cnt", 32'(done_cnt), 32'(exp_cnt + k));
            $display("rr result %0d id=%0d data=%0d", k, res_id, res_data);
            if (k < 7) begin
                chk("rr_next_grant", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
            end else begin
                @(negedge clk);
                req_valid = 4'b0000;
            end
        end
        @(posedge clk);
        exp_cnt += 8;
        #1 chk("rr_end_cnt", 32'(done_cnt), 32'(exp_cnt));
        chk("rr_end_valid", 32'(res_valid), 0);

        // Backpressure: hold the result with RES_READY low and 0110 pending
        @(negedge clk);
        req_a[7:0]   = 8'd7;
        req_b[7:0]   = 8'd2;
        req_a[15:8]  = 8'd50;
        req_b[15:8]  = 8'd60;
        req_valid    = 4'b0001;
        res_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0110;
        @(posedge clk);
        #1 chk("bp_valid", 32'(res_valid), 1);
        chk("bp_data", 32'(res_data), 9);
        chk("bp_id", 32'(res_id), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_ready", 32'(req_ready), 0);
            chk("bp_hold_valid", 32'(res_valid), 1);
            chk("bp_hold_data", 32'(res_data), 9);
            chk("bp_hold_id", 32'(res_id), 0);
            chk("bp_hold_cnt", 32'(done_cnt), 32'(exp_cnt));
        end
        res_ready = 1'b1;
        #1 chk("bp_release_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        exp_cnt++;
        #1 chk("bp_release_cnt", 32'(done_cnt), 32'(exp_cnt));
        chk("bp_release_valid", 32'(res_valid), 0);
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1 chk("bp_next_data", 32'(res_data), 246);
        chk("bp_next_id", 32'(res_id), 1);
        @(posedge clk);
        exp_cnt++;
        #1 chk("bp_next_cnt", 32'(done_cnt), 32'(exp_cnt));

        // Reset during EXEC; the pointer is 3 after this grant
        @(negedge clk);
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd5;
        req_valid    = 4'b0100;
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        exp_cnt   = 0;
        #1 chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_data", 32'(res_data), 0);
        chk("mid_rst_id", 32'(res_id), 0);
        chk("mid_rst_cnt", 32'(done_cnt), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1 chk("mid_rst_no_pulse", 32'(res_valid), 0);
        @(negedge clk);
        rst_n        = 1'b1;
        req_a[31:24] = 8'd10;
        req_b[31:24] = 8'd3;
        req_valid    = 4'b1001;
        #1 chk("post_rst_ptr0", 32'(req_ready), 32'h1);
        req_valid = 4'b1000;
        #1 chk("post_rst_grant3", 32'(req_ready), 32'h8);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1 chk("post_rst_valid", 32'(res_valid), 1);
        chk("post_rst_id", 32'(res_id), 3);
        chk("post_rst_data", 32'(res_data), 13);
        @(posedge clk);
        exp_cnt++;
        #1 chk("post_rst_cnt", 32'(done_cnt), 32'(exp_cnt));

        // RES_READY high while idle must not change the count
        repeat (3) @(posedge clk);
        #1 chk("idle_ready_cnt", 32'(done_cnt), 32'(exp_cnt));
        chk("idle_ready_valid", 32'(res_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
